easyaxi_rd_arb: RTL and testbench



---
 rtl/easyaxi_rd_arb_pkg.sv | 28 ++
 rtl/easyaxi_rd_arb_if.sv | 33 +++
 rtl/easyaxi_rr_sel.sv | 42 ++++
 rtl/easyaxi_rd_arb.sv | 141 ++++++++++++++
 tb/tb_easyaxi_rd_arb.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/easyaxi_rd_arb_pkg.sv
// Shared AXI width macros and package for the easyaxi read-channel arbiter.
// `AXI_SRC_W expands against the MST_NUM parameter of the scope that uses it.
`ifndef EASYAXI_AXI_DEFINES
`define EASYAXI_AXI_DEFINES
`define AXI_ID_W    4
`define AXI_ADDR_W  32
`define AXI_LEN_W   8
`define AXI_SIZE_W  3
`define AXI_BURST_W 2
`define AXI_USER_W  1
`define AXI_DATA_W  32
`define AXI_RESP_W  2
`define AXI_SRC_W   $clog2(MST_NUM)
`endif

package easyaxi_rd_arb_pkg;

    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_GRANT = 1'b1
    } ar_state_e;

    // Counter wide enough to hold the value max itself.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/easyaxi_rd_arb_if.sv
// AXI read bus bundle: N AR lanes with packed per-lane payload, broadcast R payload.
// Upstream side uses N=MST_NUM; downstream side uses N=1 with the widened ID.
interface easyaxi_rd_arb_if #(
    parameter int N   = 1,
    parameter int IDW = `AXI_ID_W
);
    logic [N-1:0]              arvalid;
    logic [N-1:0]              arready;
    logic [N*IDW-1:0]          arid;
    logic [N*`AXI_ADDR_W-1:0]  araddr;
    logic [N*`AXI_LEN_W-1:0]   arlen;
    logic [N*`AXI_SIZE_W-1:0]  arsize;
    logic [N*`AXI_BURST_W-1:0] arburst;
    logic [N*`AXI_USER_W-1:0]  aruser;

    logic [N-1:0]              rvalid;
    logic [N-1:0]              rready;
    logic [IDW-1:0]            rid;
    logic [`AXI_DATA_W-1:0]    rdata;
    logic [`AXI_RESP_W-1:0]    rresp;
    logic                      rlast;
    logic [`AXI_USER_W-1:0]    ruser;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, aruser, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast, ruser
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, aruser, rready,
        output arready, rvalid, rid, rdata, rresp, rlast, ruser
    );
endinterface

// File: rtl/easyaxi_rr_sel.sv
// Combinational requester picker: round-robin starting after last_i, or
// lowest-index-wins when EASYAXI_RD_ARB_FIXPRIO_EN is defined.
module easyaxi_rr_sel #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
`ifdef EASYAXI_RD_ARB_FIXPRIO_EN
    logic unused_last;
    assign unused_last = ^last_i;

    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end
`else
    always_comb begin
        int  j;
        logic found;
        j     = 0;
        found = 1'b0;
        idx_o = '0;
        any_o = |req_i;
        // Scan last+1 .. last+N with wrap; last_i is always < N.
        for (int i = 1; i <= N; i++) begin
            j = int'(last_i) + i;
            if (j >= N) j = j - N;
            if (req_i[j] && !found) begin
                idx_o = W'(j);
                found = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/easyaxi_rd_arb.sv
// N-to-1 AXI read arbiter: arbitrated AR with source-prefixed ID, R routed back by prefix.
// Define EASYAXI_RD_ARB_FIXPRIO_EN for fixed (lowest index) priority instead of round-robin.
module easyaxi_rd_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter int MST_NUM = 4,
    parameter int OST_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    easyaxi_rd_arb_if.slave  s,
    easyaxi_rd_arb_if.master m,
    output logic             rid_err
);
    localparam int SRC_W = `AXI_SRC_W;
    localparam int CNT_W = cnt_width(OST_MAX);
    localparam int MIDW  = `AXI_ID_W + SRC_W;

    ar_state_e        state_q;
    logic [SRC_W-1:0] grant_q;
    logic [SRC_W-1:0] last_q;
    logic             rid_err_q;
    logic [CNT_W-1:0] ost_q [MST_NUM];
    logic [CNT_W-1:0] ost_d [MST_NUM];

    logic [MST_NUM-1:0] elig;
    logic [MST_NUM-1:0] ost_inc;
    logic [MST_NUM-1:0] ost_dec;
    logic [SRC_W-1:0]   pick;
    logic               pick_vld;
    logic               ar_hs;
    logic [SRC_W-1:0]   r_src;
    logic               r_bad;
    logic               rlast_hs;
    int                 gidx;

    always_comb begin
        elig = '0;
        for (int k = 0; k < MST_NUM; k++) begin
            elig[k] = s.arvalid[k] && (ost_q[k] < CNT_W'(OST_MAX));
        end
    end

    easyaxi_rr_sel #(.N(MST_NUM), .W(SRC_W)) u_sel (
        .req_i  (elig),
        .last_i (last_q),
        .idx_o  (pick),
        .any_o  (pick_vld)
    );

    assign gidx  = int'(grant_q);
    assign ar_hs = (state_q == AR_GRANT) && m.arready[0];

    // AR payload is driven only while a grant is open, so idle outputs read as zero.
    always_comb begin
        m.arvalid = 1'b0;
        m.arid    = '0;
        m.araddr  = '0;
        m.arlen   = '0;
        m.arsize  = '0;
        m.arburst = '0;
        m.aruser  = '0;
        s.arready = '0;
        if (state_q == AR_GRANT) begin
            m.arvalid = 1'b1;
            m.arid    = {grant_q, s.arid[gidx*`AXI_ID_W +: `AXI_ID_W]};
            m.araddr  = s.araddr[gidx*`AXI_ADDR_W +: `AXI_ADDR_W];
            m.arlen   = s.arlen[gidx*`AXI_LEN_W +: `AXI_LEN_W];
            m.arsize  = s.arsize[gidx*`AXI_SIZE_W +: `AXI_SIZE_W];
            m.arburst = s.arburst[gidx*`AXI_BURST_W +: `AXI_BURST_W];
            m.aruser  = s.aruser[gidx*`AXI_USER_W +: `AXI_USER_W];
            s.arready[grant_q] = m.arready[0];
        end
    end

    assign r_src = m.rid[MIDW-1 -: SRC_W];
    assign r_bad = ({1'b0, r_src} >= (SRC_W + 1)'(MST_NUM));

    // Beats with an out-of-range prefix are sunk so the downstream port never stalls.
    always_comb begin
        s.rvalid  = '0;
        m.rready  = 1'b1;
        if (!r_bad) begin
            s.rvalid[r_src] = m.rvalid[0];
            m.rready        = s.rready[r_src];
        end
    end

    assign s.rid   = m.rid[`AXI_ID_W-1:0];
    assign s.rdata = m.rdata;
    assign s.rresp = m.rresp;
    assign s.rlast = m.rlast;
    assign s.ruser = m.ruser;

    assign rlast_hs = m.rvalid[0] && m.rready[0] && m.rlast && !r_bad;

    always_comb begin
        ost_inc = '0;
        ost_dec = '0;
        for (int k = 0; k < MST_NUM; k++) begin
            ost_inc[k] = ar_hs && (grant_q == SRC_W'(k));
            ost_dec[k] = rlast_hs && (r_src == SRC_W'(k));
            ost_d[k]   = ost_q[k];
            if (ost_inc[k] && !ost_dec[k]) begin
                ost_d[k] = ost_q[k] + 1'b1;
            end else if (ost_dec[k] && !ost_inc[k] && (ost_q[k] != '0)) begin
                ost_d[k] = ost_q[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= AR_IDLE;
            grant_q   <= '0;
            last_q    <= SRC_W'(MST_NUM - 1);
            rid_err_q <= 1'b0;
            for (int k = 0; k < MST_NUM; k++) ost_q[k] <= '0;
        end else begin
            for (int k = 0; k < MST_NUM; k++) ost_q[k] <= ost_d[k];
            if (m.rvalid[0] && r_bad) rid_err_q <= 1'b1;
            case (state_q)
                AR_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick;
                        state_q <= AR_GRANT;
                    end
                end
                AR_GRANT: begin
                    if (m.arready[0]) begin
                        last_q  <= grant_q;
                        state_q <= AR_IDLE;
                    end
                end
                default: state_q <= AR_IDLE;
            endcase
        end
    end

    assign rid_err = rid_err_q;
endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Self-checking bench for easyaxi_rd_arb: directed scenarios followed by a random phase,
// each cycle compared against a behavioural model of the arbitration/routing rules.
module tb_easyaxi_rd_arb;
    localparam int NM   = 5;
    localparam int OSTM = 8;
    localparam int IDW  = 4;
    localparam int SW   = 3;

    logic clk;
    logic rst;
    logic rid_err;

    easyaxi_rd_arb_if #(.N(NM), .IDW(IDW))      up ();
    easyaxi_rd_arb_if #(.N(1),  .IDW(IDW + SW)) dn ();

    easyaxi_rd_arb #(.MST_NUM(NM), .OST_MAX(OSTM)) dut (
        .clk     (clk),
        .rst     (rst),
        .s       (up),
        .m       (dn),
        .rid_err (rid_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state: open grant, granted source, last winner, open bursts, sticky error.
    int m_act;
    int m_gnt;
    int m_last;
    int m_ost [NM];
    bit m_err;

    logic [0:0]    obs_arvalid;
    logic [6:0]    obs_arid;
    logic [NM-1:0] obs_arready;
    logic          obs_rready;
    logic [NM-1:0] obs_rvalid;
    logic          obs_err;
    logic [NM-1:0] acc_ar;
    bit            r_hs;
    bit            r_hs_last;
    bit            ar_acc;
    int            ar_src;
    int            hs_log [$];
    int            hs_cyc [$];
    int            oq [$];
    int            cur;
    bit            beat_vld;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NM-1:0] el, input int last);
`ifdef EASYAXI_RD_ARB_FIXPRIO_EN
        for (int i = 0; i < NM; i++) if (el[i]) return i;
`else
        for (int i = 1; i <= NM; i++) if (el[(last + i) % NM]) return (last + i) % NM;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_act  = 0;
        m_gnt  = 0;
        m_last = NM - 1;
        m_err  = 1'b0;
        for (int k = 0; k < NM; k++) m_ost[k] = 0;
    endtask

    task automatic tick();
        int            src;
        bit            bad;
        logic [NM-1:0] e_arr;
        logic [NM-1:0] e_rv;
        logic [NM-1:0] el;
        logic          e_rr;
        logic [6:0]    e_arid;
        logic [31:0]   e_addr;
        logic [7:0]    e_len;
        bit            hs;
        bit            rl;
        int            n_ost [NM];
        int            pk;
        int            n_act;
        int            n_gnt;
        int            n_last;
        bit            n_err;
        @(negedge clk);
        if (rst) model_reset();
        e_arr  = '0;
        e_arid = '0;
        e_addr = '0;
        e_len  = '0;
        if (m_act != 0) begin
            e_arr[m_gnt] = dn.arready[0];
            e_arid = {3'(m_gnt), up.arid[m_gnt*IDW +: IDW]};
            e_addr = up.araddr[m_gnt*32 +: 32];
            e_len  = up.arlen[m_gnt*8 +: 8];
        end
        src  = int'(dn.rid[6:4]);
        bad  = (src >= NM);
        e_rv = '0;
        e_rr = 1'b1;
        if (!bad) begin
            e_rv[src] = dn.rvalid[0];
            e_rr      = up.rready[src];
        end
        chk("m_arvalid", dn.arvalid, (m_act != 0));
        chk("s_arready", up.arready, e_arr);
        chk("m_arid", dn.arid, e_arid);
        chk("m_araddr", dn.araddr, e_addr);
        chk("m_arlen", dn.arlen, e_len);
        chk("s_rvalid", up.rvalid, e_rv);
        chk("m_rready", dn.rready, e_rr);
        chk("rid_err", rid_err, m_err);
        chk("s_rdata", {up.rid, up.rdata}, {dn.rid[3:0], dn.rdata});

        obs_arvalid = dn.arvalid;
        obs_arid    = dn.arid;
        obs_arready = up.arready;
        obs_rready  = dn.rready[0];
        obs_rvalid  = up.rvalid;
        obs_err     = rid_err;
        if (dn.arvalid[0] && dn.arready[0]) begin
            hs_log.push_back(int'(dn.arid[6:4]));
            hs_cyc.push_back(cyc);
        end

        hs        = (m_act != 0) && dn.arready[0];
        rl        = dn.rvalid[0] && e_rr && dn.rlast && !bad;
        acc_ar    = up.arvalid & e_arr;
        r_hs      = dn.rvalid[0] && e_rr;
        r_hs_last = r_hs && dn.rlast;
        ar_acc    = hs;
        ar_src    = m_gnt;

        for (int k = 0; k < NM; k++) begin
            bit inc;
            bit dec;
            inc      = hs && (m_gnt == k);
            dec      = rl && (src == k);
            el[k]    = up.arvalid[k] && (m_ost[k] < OSTM);
            n_ost[k] = m_ost[k];
            if (inc && !dec) n_ost[k] = m_ost[k] + 1;
            else if (dec && !inc && m_ost[k] > 0) n_ost[k] = m_ost[k] - 1;
        end
        n_err  = m_err | (dn.rvalid[0] && bad);
        n_act  = m_act;
        n_gnt  = m_gnt;
        n_last = m_last;
        if (m_act == 0) begin
            pk = rr_pick(el, m_last);
            if (pk >= 0) begin
                n_act = 1;
                n_gnt = pk;
            end
        end else if (hs) begin
            n_act  = 0;
            n_last = m_gnt;
        end

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_act  = n_act;
            m_gnt  = n_gnt;
            m_last = n_last;
            m_err  = n_err;
            for (int k = 0; k < NM; k++) m_ost[k] = n_ost[k];
        end
        cyc++;
        #1;
    endtask

    task automatic set_src(input int k);
        up.arvalid[k]        = 1'b1;
        up.arid[k*IDW +: IDW] = 4'($urandom);
        up.araddr[k*32 +: 32] = $urandom;
        up.arlen[k*8 +: 8]    = 8'($urandom);
        up.arsize[k*3 +: 3]   = 3'($urandom);
        up.arburst[k*2 +: 2]  = 2'($urandom);
        up.aruser[k]          = 1'($urandom);
    endtask

    task automatic r_beat(input int s, input bit last);
        dn.rvalid = 1'b1;
        dn.rid    = 7'((s << 4) | int'($urandom_range(15, 0)));
        dn.rlast  = last;
        dn.rdata  = $urandom;
        dn.rresp  = 2'($urandom);
        dn.ruser  = 1'($urandom);
    endtask

    task automatic do_reset();
        up.arvalid = '0;
        dn.rvalid  = '0;
        dn.rlast   = 1'b0;
        dn.rid     = '0;
        up.rready  = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        up.arvalid = '0;
        up.arid    = '0;
        up.araddr  = '0;
        up.arlen   = '0;
        up.arsize  = '0;
        up.arburst = '0;
        up.aruser  = '0;
        up.rready  = '0;
        dn.arready = '0;
        dn.rvalid  = '0;
        dn.rid     = '0;
        dn.rdata   = '0;
        dn.rresp   = '0;
        dn.rlast   = 1'b0;
        dn.ruser   = '0;
        cur        = 0;
        beat_vld   = 1'b0;
        model_reset();

        tick();
        tick();
        chk("rst_arvalid", obs_arvalid, 0);
        chk("rst_arready", obs_arready, 0);
        chk("rst_rid_err", obs_err, 0);
        rst = 1'b0;

        // Four sources requesting continuously: grants rotate 0,1,2,3,0.
        hs_log.delete();
        hs_cyc.delete();
        for (int k = 0; k < 4; k++) set_src(k);
        dn.arready = 1'b1;
        repeat (10) tick();
        chk("rr_count", hs_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", (i < hs_log.size()) ? hs_log[i] : -1, i % 4);
        end
        for (int i = 1; i < 5; i++) begin
            chk("rr_spacing", (i < hs_cyc.size()) ? hs_cyc[i] - hs_cyc[i-1] : -1, 2);
        end
        do_reset();

        // Source 2 fills its outstanding budget, then one rlast frees a slot.
        hs_log.delete();
        set_src(2);
        dn.arready = 1'b1;
        repeat (20) tick();
        chk("ost_issued", hs_log.size(), 8);
        chk("ost_blocked", obs_arvalid, 0);
        up.rready = 5'b00100;
        r_beat(2, 1'b1);
        tick();
        dn.rvalid  = '0;
        dn.rlast   = 1'b0;
        dn.arready = 1'b0;
        tick();
        chk("ost_wait", obs_arvalid, 0);
        set_src(0);
        set_src(1);
        tick();
        chk("ost_regrant", obs_arvalid, 1);
        chk("ost_regrant_src", obs_arid[6:4], 2);

        // Downstream stalls: grant and payload stay put, no upstream ready.
        repeat (4) begin
            tick();
            chk("hold_arvalid", obs_arvalid, 1);
            chk("hold_src", obs_arid[6:4], 2);
            chk("hold_arready", obs_arready, 0);
        end
        dn.arready = 1'b1;
        tick();
        chk("hold_release", obs_arready, 5'b00100);
        do_reset();

        // Interleaved bursts from sources 1 and 3, source 3 back-pressured.
        set_src(1);
        set_src(3);
        dn.arready = 1'b1;
        repeat (4) tick();
        up.arvalid = '0;
        up.rready  = 5'b10111;
        r_beat(1, 1'b0);
        tick();
        chk("il_rready_1a", obs_rready, 1);
        r_beat(3, 1'b0);
        repeat (2) begin
            tick();
            chk("il_rready_3stall", obs_rready, 0);
            chk("il_rvalid_3", obs_rvalid, 5'b01000);
        end
        r_beat(1, 1'b1);
        tick();
        chk("il_rready_1b", obs_rready, 1);
        chk("il_rvalid_1", obs_rvalid, 5'b00010);
        up.rready[3] = 1'b1;
        r_beat(3, 1'b0);
        tick();
        r_beat(3, 1'b1);
        tick();
        chk("il_rready_3b", obs_rready, 1);
        dn.rvalid = '0;
        dn.rlast  = 1'b0;

        // Out-of-range prefix is sunk and latches rid_err until reset.
        up.rready = '0;
        dn.rvalid = 1'b1;
        dn.rid    = {3'd5, 4'h9};
        dn.rlast  = 1'b1;
        tick();
        chk("bad_rready", obs_rready, 1);
        chk("bad_rvalid", obs_rvalid, 0);
        dn.rvalid = '0;
        dn.rlast  = 1'b0;
        dn.rid    = '0;
        repeat (3) begin
            tick();
            chk("bad_sticky", obs_err, 1);
        end
        rst = 1'b1;
        tick();
        chk("bad_rst_clear", obs_err, 0);
        rst = 1'b0;

        // AR handshake and rlast for source 0 in one cycle leave its count at 3.
        set_src(0);
        dn.arready = 1'b1;
        repeat (6) tick();
        dn.arready = 1'b0;
        tick();
        dn.arready = 1'b1;
        up.rready  = 5'b00001;
        r_beat(0, 1'b1);
        tick();
        chk("sc_ar_hs", obs_arready, 5'b00001);
        chk("sc_r_hs", obs_rready, 1);
        dn.rvalid = '0;
        dn.rlast  = 1'b0;
        hs_log.delete();
        repeat (20) tick();
        chk("sc_remaining", hs_log.size(), 5);
        do_reset();

        // Random traffic with AXI-legal holding of valids.
        oq.delete();
        beat_vld = 1'b0;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NM; k++) begin
                if (acc_ar[k]) up.arvalid[k] = 1'b0;
                if (!up.arvalid[k] && ($urandom % 3 == 0)) set_src(k);
            end
            dn.arready = 1'($urandom % 4 != 0);
            up.rready  = NM'($urandom);
            if (r_hs && beat_vld) begin
                if (r_hs_last) begin
                    if (cur < oq.size()) oq.delete(cur);
                    beat_vld  = 1'b0;
                    dn.rvalid = '0;
                    dn.rlast  = 1'b0;
                end else begin
                    r_beat(oq[cur], 1'($urandom % 2));
                end
            end
            if (ar_acc) oq.push_back(ar_src);
            if (!beat_vld && oq.size() > 0 && ($urandom % 2 == 1)) begin
                cur = int'($urandom % oq.size());
                r_beat(oq[cur], 1'($urandom % 2));
                beat_vld = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
